// File: rtl/core_defs_pkg.sv
// core_defs: shared constants and payload type for the ID/EX boundary.
//   DEF_NOP_INST / DEF_RST_PC : bubble values seen by ex when no entry is held
//   OP_* / F3_*               : RV32I opcode and funct3 constants
//   id_ex_pld_t               : 134-bit decoded payload carried from id to ex
package core_defs;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] DEF_RST_PC   = 32'h0000_0000;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam int PLD_W = 134;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        reg_wen;
  } id_ex_pld_t;

  // Payload ex sees while no valid entry is held.
  function automatic id_ex_pld_t bubble(input logic [31:0] nop, input logic [31:0] pc);
    id_ex_pld_t p;
    p           = '0;
    p.inst      = nop;
    p.inst_addr = pc;
    return p;
  endfunction

endpackage

// File: rtl/id_ex_reg_slot.sv
// id_ex_slot: one payload register plus its valid bit.
//   i_clear wins over i_load; a cleared slot holds CLR_VAL so that an empty
//   main slot already presents the bubble payload straight from its flops.
// Ports: clk, rst_n (async low), i_load, i_clear, i_data -> o_valid, o_data
module id_ex_slot
  import core_defs::*;
#(
  parameter logic [PLD_W-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [PLD_W-1:0] i_data,
  output logic             o_valid,
  output logic [PLD_W-1:0] o_data
);

  logic             r_valid;
  logic [PLD_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= CLR_VAL;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= CLR_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with a 2-entry skid buffer.
//   id side : id_valid_i / id_ready_o, payload inst/inst_addr/op1/op2/rd/wen
//   ex side : ex_valid_o / ex_ready_i, same payload fields as *_o
//   flush_i : drops every held entry and any payload offered that cycle
//   stall_cnt_o : cycles with ex_valid_o & !ex_ready_i, present only when
//                 ID_EX_STALL_CNT_EN is defined (otherwise tied to zero)
// id_ready_o comes from the skid valid flop only, so ex_ready_i never
// reaches the id side combinationally.
module id_ex_reg
  import core_defs::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST,
  parameter logic [31:0] RST_PC   = DEF_RST_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic [31:0] stall_cnt_o
);

  localparam id_ex_pld_t BUBBLE = bubble(NOP_INST, RST_PC);

  id_ex_pld_t w_in, w_main_q, w_skid_q, w_main_d;
  logic       w_main_v, w_skid_v, w_acc, w_dlv;
  logic       w_main_ld, w_main_clr, w_skid_ld, w_skid_clr;

  assign w_in = '{inst: inst_i, inst_addr: inst_addr_i, op1: op1_i, op2: op2_i,
                  rd_addr: rd_addr_i, reg_wen: reg_wen_i};

  assign w_acc = id_valid_i & ~w_skid_v;
  assign w_dlv = w_main_v & ex_ready_i;

  // Main refills from skid when skid holds the older entry, else from id.
  assign w_main_d   = w_skid_v ? w_skid_q : w_in;
  assign w_main_ld  = ~flush_i & ((~w_main_v & w_acc) | (w_dlv & (w_skid_v | w_acc)));
  // Clearing main on a drain keeps the bubble values in the output flops.
  assign w_main_clr = flush_i | (w_dlv & ~w_skid_v & ~w_acc);
  assign w_skid_ld  = ~flush_i & w_main_v & ~w_skid_v & ~w_dlv & w_acc;
  assign w_skid_clr = flush_i | (w_skid_v & w_dlv);

  id_ex_slot #(.CLR_VAL(BUBBLE)) u_main (
    .clk(clk), .rst_n(rst_n), .i_load(w_main_ld), .i_clear(w_main_clr),
    .i_data(w_main_d), .o_valid(w_main_v), .o_data(w_main_q)
  );

  id_ex_slot #(.CLR_VAL(BUBBLE)) u_skid (
    .clk(clk), .rst_n(rst_n), .i_load(w_skid_ld), .i_clear(w_skid_clr),
    .i_data(w_in), .o_valid(w_skid_v), .o_data(w_skid_q)
  );

  assign id_ready_o  = ~w_skid_v;
  assign ex_valid_o  = w_main_v;
  assign inst_o      = w_main_q.inst;
  assign inst_addr_o = w_main_q.inst_addr;
  assign op1_o       = w_main_q.op1;
  assign op2_o       = w_main_q.op2;
  assign rd_addr_o   = w_main_q.rd_addr;
  assign reg_wen_o   = w_main_q.reg_wen;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running wrap; flush leaves it alone so stall history survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_stall_cnt <= '0;
    else if (w_main_v & ~ex_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid_i = 1'b0, ex_ready_i = 1'b0, flush_i = 1'b0, reg_wen_i = 1'b0;
  logic [31:0] inst_i = '0, inst_addr_i = '0, op1_i = '0, op2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        id_ready_o, ex_valid_o, reg_wen_o;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, stall_cnt_o;
  logic [4:0]  rd_addr_o;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst, pc, op1, op2;
    logic [4:0]  rd;
    logic        wen;
  } pld_t;

  pld_t        q[$];        // entries held, oldest first
  logic [31:0] m_cnt = '0;
  bit          chk_en = 1'b0;
  bit          pre = 1'b0;  // model preload of the stall counter
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a queue of at most two entries; ready while fewer than two held.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_cnt = '0;
    end else begin
      automatic int  n   = q.size();
      automatic bit  dlv = (n > 0) && ex_ready_i;
      automatic bit  acc = id_valid_i && (n < 2);
      automatic pld_t p  = '{inst: inst_i, pc: inst_addr_i, op1: op1_i, op2: op2_i,
                             rd: rd_addr_i, wen: reg_wen_i};
`ifdef ID_EX_STALL_CNT_EN
      m_cnt = (pre ? 32'hFFFF_FFFF : m_cnt) + ((n > 0 && !ex_ready_i) ? 32'd1 : 32'd0);
`endif
      if (flush_i) q.delete();
      else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
    end
  end

  // Compare process: every falling edge out of reset.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      automatic pld_t e = (q.size() > 0) ? q[0] :
                          '{inst: 32'h13, pc: 32'h0, op1: 32'h0, op2: 32'h0, rd: 5'd0, wen: 1'b0};
      chk("m_ex_valid", {31'd0, ex_valid_o}, {31'd0, q.size() > 0});
      chk("m_id_ready", {31'd0, id_ready_o}, {31'd0, q.size() < 2});
      chk("m_inst", inst_o, e.inst);
      chk("m_pc", inst_addr_o, e.pc);
      chk("m_op1", op1_o, e.op1);
      chk("m_op2", op2_o, e.op2);
      chk("m_rd", {27'd0, rd_addr_o}, {27'd0, e.rd});
      chk("m_wen", {31'd0, reg_wen_o}, {31'd0, e.wen});
      chk("m_stall", stall_cnt_o, m_cnt);
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    id_valid_i  = v;
    inst_i      = ins;
    inst_addr_i = pc;
    op1_i       = pc ^ 32'h1111_0000;
    op2_i       = 32'd5;
    rd_addr_i   = ins[11:7];
    reg_wen_i   = v;
    ex_ready_i  = rdy;
    flush_i     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;  // addi x1,x0,5

  initial begin
    // Reset values, sampled mid-cycle while rst_n is low.
    #12;
    chk("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'h13);
    chk("rst_id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("rst_wen", {31'd0, reg_wen_o}, 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Streaming: one per cycle, one cycle latency.
    drive(1, ADDI, 32'h0, 1, 0); step();
    chk("str_v0", {31'd0, ex_valid_o}, 32'd1);
    chk("str_pc0", inst_addr_o, 32'h0);
    chk("str_inst0", inst_o, ADDI);
    chk("str_rd0", {27'd0, rd_addr_o}, 32'd1);
    drive(1, ADDI, 32'h4, 1, 0); step();
    chk("str_pc4", inst_addr_o, 32'h4);
    drive(1, ADDI, 32'h8, 1, 0); step();
    chk("str_pc8", inst_addr_o, 32'h8);
    drive(0, 32'h0, 32'h0, 1, 0); step();
    chk("str_drain", {31'd0, ex_valid_o}, 32'd0);

    // Backpressure: two held, third waits.
    drive(1, ADDI, 32'h0, 0, 0); step();
    chk("bp_rdy1", {31'd0, id_ready_o}, 32'd1);
    drive(1, ADDI, 32'h4, 0, 0); step();
    chk("bp_rdy_full", {31'd0, id_ready_o}, 32'd0);
    drive(1, ADDI, 32'h8, 0, 0); step();
    chk("bp_hold_pc", inst_addr_o, 32'h0);
    drive(1, ADDI, 32'h8, 1, 0); step();
    chk("bp_pc4", inst_addr_o, 32'h4);
    chk("bp_rdy_again", {31'd0, id_ready_o}, 32'd1);
    step();
    chk("bp_pc8", inst_addr_o, 32'h8);
    drive(0, 32'h0, 32'h0, 1, 0); step();
    chk("bp_empty", {31'd0, ex_valid_o}, 32'd0);

    // Flush while FULL with a payload offered.
    drive(1, ADDI, 32'h10, 0, 0); step();
    drive(1, ADDI, 32'h14, 0, 0); step();
    drive(1, ADDI, 32'h18, 0, 1); step();
    chk("fl_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("fl_inst", inst_o, 32'h13);
    chk("fl_pc", inst_addr_o, 32'h0);
    chk("fl_wen", {31'd0, reg_wen_o}, 32'd0);
    chk("fl_rdy", {31'd0, id_ready_o}, 32'd1);
    drive(0, 32'h0, 32'h0, 1, 0); step();
    chk("fl_dropped", {31'd0, ex_valid_o}, 32'd0);

    // Asynchronous reset between edges while FULL.
    drive(1, ADDI, 32'h20, 0, 0); step();
    drive(1, ADDI, 32'h24, 0, 0); step();
    drive(0, 32'h0, 32'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("ar_inst", inst_o, 32'h13);
    chk("ar_rdy", {31'd0, id_ready_o}, 32'd1);
    chk("ar_op1", op1_o, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Stall counter: seven stalled cycles, then wrap from all-ones.
    drive(1, ADDI, 32'h100, 0, 0); step();
    drive(0, 32'h0, 32'h0, 0, 0);
    repeat (7) step();
`ifdef ID_EX_STALL_CNT_EN
    chk("stall_7", stall_cnt_o, 32'd7);
    chk_en = 1'b0;
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_stall_cnt;
    pre = 1'b1;
    step();
    pre = 1'b0;
    chk_en = 1'b1;
    chk("stall_wrap", stall_cnt_o, 32'd0);
`else
    chk("stall_off", stall_cnt_o, 32'd0);
`endif
    chk("stall_hold_pc", inst_addr_o, 32'h100);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      id_valid_i  = ($urandom % 4) != 0;
      ex_ready_i  = $urandom % 2;
      flush_i     = ($urandom % 16) == 0;
      inst_i      = $urandom;
      inst_addr_i = $urandom;
      op1_i       = $urandom;
      op2_i       = $urandom;
      rd_addr_i   = 5'($urandom);
      reg_wen_i   = $urandom % 2;
      step();
    end

    drive(0, 32'h0, 32'h0, 1, 0);
    repeat (3) step();
    chk("final_empty", {31'd0, ex_valid_o}, 32'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode stage (id) and the execute stage (ex) of the RV32I core.
- Captures the decoded payload: inst, inst_addr, op1, op2, rd_addr, reg_wen.
- Uses a valid/ready handshake and a 2-entry skid buffer, so that id_ready_o is driven from a register (no combinational path from ex_ready_i).
- Supports flush from a branch/jump resolved in ex; a flush inserts a NOP bubble.

Parameters:
- NOP_INST, 32'h0000_0013, instruction word driven on inst_o when no valid entry (addi x0,x0,0)
- RST_PC, 32'h0000_0000, value on inst_addr_o at reset and during bubbles

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid_i  input  1  id presents a valid payload
- id_ready_o  output  1  register can accept a payload this cycle
- inst_i  input  32  decoded instruction word
- inst_addr_i  input  32  instruction PC
- op1_i  input  32  operand 1
- op2_i  input  32  operand 2 / sign-extended immediate
- rd_addr_i  input  5  destination register
- reg_wen_i  input  1  register write enable
- flush_i  input  1  discard all held entries (branch taken in ex)
- ex_valid_o  output  1  payload on the ex side is valid
- ex_ready_i  input  1  ex consumes the payload this cycle
- inst_o  output  32  payload to ex
- inst_addr_o  output  32  payload to ex
- op1_o  output  32  payload to ex
- op2_o  output  32  payload to ex
- rd_addr_o  output  5  payload to ex
- reg_wen_o  output  1  payload to ex; forced to 0 whenever ex_valid_o=0
- stall_cnt_o  output  32  ex-side stall counter (see Optional Feature)

Behaviour:
- Storage: main slot (drives the ex outputs) and skid slot, each with its own valid bit.
- Reset (async, rst_n=0): both valid bits 0.
  - Register outputs: id_ready_o=1, ex_valid_o=0, inst_o=NOP_INST, inst_addr_o=RST_PC.
  - op1_o=0, op2_o=0, rd_addr_o=0, reg_wen_o=0, stall_cnt_o=0.
- Handshake:
  - Accept on id_valid_i & id_ready_o.
  - Deliver on ex_valid_o & ex_ready_i.
  - id_ready_o = !skid_valid, registered.
- States (derived from the valid bits):
  - EMPTY: main=0, skid=0.
    - Accept: load main -> BUSY. Latency is 1 cycle from accept to ex_valid_o.
  - BUSY: main=1, skid=0.
    - Accept + deliver: main reloads, stays BUSY.
    - Deliver only: -> EMPTY.
    - Accept only: load skid -> FULL; id_ready_o falls next cycle.
  - FULL: main=1, skid=1; id_ready_o=0.
    - Deliver: skid moves to main -> BUSY.
    - id_valid_i is ignored in this state.
- Flush:
  - flush_i=1 at a clock edge clears both valid bits, reaching EMPTY next cycle.
  - It also drops any payload being accepted in that same cycle, i.e. flush has priority over accept and deliver.
  - Main outputs revert to the NOP/zero bubble values.
- Bubble rule: when ex_valid_o=0, inst_o=NOP_INST, inst_addr_o=RST_PC, reg_wen_o=0, rd_addr_o=0, op1_o=0, op2_o=0.
- Ordering: payloads are delivered in strict accept order; none are lost or duplicated.
- Data path: payload fields pass through bit-exact; no arithmetic is performed.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit counter.
  - Increments each cycle ex_valid_o=1 & ex_ready_i=0; wraps 32'hFFFF_FFFF -> 0.
  - Not cleared by flush; cleared only by reset.
- Undefined: stall_cnt_o is tied to 32'h0 and no counter flops exist.

Decomposition:
- Shared package/header core_defs: NOP_INST, RST_PC, opcode constants (OP_IMM=7'b0010011), funct3 constants, payload width 134.
- Natural sub-module: id_ex_slot, a payload register (134 bits plus valid) with load and clear.
  - Instantiated twice: main and skid.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> ex_valid_o=0, inst_o=32'h13, id_ready_o=1, reg_wen_o=0, stall_cnt_o=0.
- Streaming: id_valid_i=1 and ex_ready_i=1 continuously, feeding addi x1,x0,5 (inst 32'h00500093, PC 0x0, 0x4, 0x8) -> same payloads on ex one cycle later, one per cycle, in order.
- Backpressure: ex_ready_i=0 while 3 payloads are offered -> 2 are held, id_ready_o=0 after the 2nd accept. Then ex_ready_i=1 -> delivered PC 0x0, 0x4, then the 3rd is accepted; nothing lost.
- Flush in FULL with id_valid_i=1 -> next cycle EMPTY, ex_valid_o=0, inst_o=32'h13, reg_wen_o=0, id_ready_o=1; the offered payload is dropped.
- Asynchronous reset asserted between edges while FULL -> outputs take reset values immediately, without waiting for clk.
- With ID_EX_STALL_CNT_EN: hold ex_valid_o=1 and ex_ready_i=0 for 7 cycles -> stall_cnt_o=7. Preload via force to 32'hFFFF_FFFF, one stall cycle -> 0.
